// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler beside the E stage.
// Owns HI/LO, models fixed MD latency, raises the D-stage MD stall.
module md_sched #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic [31:0] v_A_E,
    input  logic [31:0] v_B_E,
    input  logic        h_MD_D,
    output logic        start,
    output logic        busy,
    output logic        stall_MD,
    output logic [31:0] v_HI,
    output logic [31:0] v_LO,
    output logic [31:0] v_MD_E
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [4:0] MULT_CNT = 5'(MULT_LAT);
    localparam logic [4:0] DIV_CNT  = 5'(DIV_LAT);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        is_mul;
    logic        is_div;
    logic        is_signed;
    logic        div_zero;

    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo;
    logic [31:0] rem;

    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Decode the E-stage opcode into operation classes.
    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        unique case (1'b1)
            (md_op_E == OP_MULT):  begin is_mul = 1'b1; is_signed = 1'b1; end
            (md_op_E == OP_MULTU): is_mul = 1'b1;
            (md_op_E == OP_DIV):   begin is_div = 1'b1; is_signed = 1'b1; end
            (md_op_E == OP_DIVU):  is_div = 1'b1;
            default: ;
        endcase
    end

    assign div_zero = (v_B_E == 32'd0);

    // Low 64 bits of the product of sign- or zero-extended operands
    // equal the true 32x32 product in either signedness.
    assign ext_a = {{32{is_signed & v_A_E[31]}}, v_A_E};
    assign ext_b = {{32{is_signed & v_B_E[31]}}, v_B_E};
    assign prod  = ext_a * ext_b;

    // Signed divide on magnitudes; -2^31 / -1 wraps back to 0x80000000.
    assign neg_a = is_signed & v_A_E[31];
    assign neg_b = is_signed & v_B_E[31];
    assign mag_a = neg_a ? (32'd0 - v_A_E) : v_A_E;
    assign mag_b = neg_b ? (32'd0 - v_B_E) : v_B_E;

    // Unsigned core divider; guarded so a zero divisor yields zeros.
    always_comb begin
        quo_u = 32'd0;
        rem_u = 32'd0;
        if (mag_b != 32'd0) begin
            quo_u = mag_a / mag_b;
            rem_u = mag_a % mag_b;
        end
    end

    assign quo = (neg_a ^ neg_b) ? (32'd0 - quo_u) : quo_u;
    assign rem = neg_a ? (32'd0 - rem_u) : rem_u;

    // Select the HI/LO pair the starting operation will commit.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (is_mul) begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end else if (is_div) begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    // Next-state and start logic for the IDLE/BUSY scheduler.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        start     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (is_mul || is_div) begin
                    start     = 1'b1;
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_wr_d = !(is_div && div_zero);
                    cnt_d     = is_mul ? MULT_CNT : DIV_CNT;
                    state_d   = S_BUSY;
                end else if (md_op_E == OP_MTHI) begin
                    hi_d = v_A_E;
                end else if (md_op_E == OP_MTLO) begin
                    lo_d = v_A_E;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    cnt_d     = 5'd0;
                    state_d   = S_IDLE;
                    pend_wr_d = 1'b0;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 5'd0;
            end
        endcase
    end

    // State registers; reset aborts any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Read port for mfhi/mflo; reads are allowed even while busy.
    always_comb begin
        v_MD_E = 32'd0;
        unique case (1'b1)
            (md_op_E == OP_MFHI): v_MD_E = hi_q;
            (md_op_E == OP_MFLO): v_MD_E = lo_q;
            default: ;
        endcase
    end

    assign busy     = (state_q == S_BUSY);
    assign stall_MD = h_MD_D & (start | busy);
    assign v_HI     = hi_q;
    assign v_LO     = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed and random checks of md_sched against
// a transaction-level HI/LO model with cycle-stamped completion.
module tb_md_sched;

    localparam int ML = 5;
    localparam int DL = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  md_op_E;
    logic [31:0] v_A_E;
    logic [31:0] v_B_E;
    logic        h_MD_D;
    logic        start;
    logic        busy;
    logic        stall_MD;
    logic [31:0] v_HI;
    logic [31:0] v_LO;
    logic [31:0] v_MD_E;

    md_sched #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op_E  (md_op_E),
        .v_A_E    (v_A_E),
        .v_B_E    (v_B_E),
        .h_MD_D   (h_MD_D),
        .start    (start),
        .busy     (busy),
        .stall_MD (stall_MD),
        .v_HI     (v_HI),
        .v_LO     (v_LO),
        .v_MD_E   (v_MD_E)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int          cyc    = 0;
    int          done_c = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic [31:0] p_hi   = 32'd0;
    logic [31:0] p_lo   = 32'd0;
    bit          p_wr   = 1'b0;

    logic [98:0] obs;
    assign obs = {start, busy, stall_MD, v_HI, v_LO, v_MD_E};

    function automatic logic [63:0] calc(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
        longint sa, sb, q, rm;
        longint unsigned ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = 64'(a);
        ub = 64'(b);
        case (op)
            4'd1: begin q = sa * sb; return q; end
            4'd2: begin p = ua * ub; return p; end
            4'd3: begin
                if (b == 0) return 64'd0;
                q  = sa / sb;
                rm = sa % sb;
                return {rm[31:0], q[31:0]};
            end
            4'd4: begin
                if (b == 0) return 64'd0;
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [98:0] exp_vec();
        logic        s, bz;
        logic [31:0] md;
        bz = (cyc < done_c);
        s  = (md_op_E inside {[4'd1:4'd4]}) && !bz;
        md = (md_op_E == 4'd7) ? m_hi :
             (md_op_E == 4'd8) ? m_lo : 32'd0;
        return {s, bz, h_MD_D & (s | bz), m_hi, m_lo, md};
    endfunction

    function automatic void model_edge();
        logic [63:0] r;
        if (reset) begin
            m_hi   = 32'd0;
            m_lo   = 32'd0;
            p_wr   = 1'b0;
            done_c = cyc + 1;
        end else if (cyc < done_c) begin
            if (cyc + 1 == done_c && p_wr) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (md_op_E inside {[4'd1:4'd4]}) begin
            r      = calc(md_op_E, v_A_E, v_B_E);
            p_hi   = r[63:32];
            p_lo   = r[31:0];
            p_wr   = !(md_op_E >= 4'd3 && v_B_E == 32'd0);
            done_c = cyc + 1 + ((md_op_E <= 4'd2) ? ML : DL);
        end else if (md_op_E == 4'd5) begin
            m_hi = v_A_E;
        end else if (md_op_E == 4'd6) begin
            m_lo = v_A_E;
        end
        cyc++;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic h,
                         input logic r);
        md_op_E = op;
        v_A_E   = a;
        v_B_E   = b;
        h_MD_D  = h;
        reset   = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
        step();
        step();
        drive(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        n_chk++;
        if ({busy, stall_MD, v_HI, v_LO} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=0",
                     {busy, stall_MD, v_HI, v_LO});
        end
        n_chk++;
        if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_vec got=%h exp=%h", obs, exp_vec());
        end
        step();
    endtask

    task automatic test_mult();
        for (int i = 0; i <= ML; i++) begin
            drive((i == 0) ? 4'd1 : 4'd0, 32'hFFFF_FFFD, 32'd5,
                  1'b0, 1'b0);
            n_chk++;
            if (busy !== (i != 0) || start !== (i == 0)) begin
                n_fail++;
                $display("FAIL mult_busy i=%0d got=%b%b exp=%b%b",
                         i, start, busy, i == 0, i != 0);
            end
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_chk++;
        if ({busy, v_HI, v_LO} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1}) begin
            n_fail++;
            $display("FAIL mult_result got=%b %h %h exp=0 ffffffff fffffff1",
                     busy, v_HI, v_LO);
        end
        step();
    endtask

    task automatic test_multu_div();
        for (int i = 0; i <= ML; i++) begin
            drive((i == 0) ? 4'd2 : 4'd0, 32'hFFFF_FFFF, 32'd2,
                  1'b0, 1'b0);
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_chk++;
        if ({v_HI, v_LO} !== {32'h1, 32'hFFFF_FFFE}) begin
            n_fail++;
            $display("FAIL multu_result got=%h %h exp=00000001 fffffffe",
                     v_HI, v_LO);
        end
        for (int i = 0; i <= DL; i++) begin
            drive((i == 0) ? 4'd3 : 4'd0, 32'hFFFF_FFF9, 32'd2,
                  1'b0, 1'b0);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL div_cycle i=%0d got=%h exp=%h",
                         i, obs, exp_vec());
            end
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_chk++;
        if ({busy, v_HI, v_LO} !== {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            n_fail++;
            $display("FAIL div_result got=%b %h %h exp=0 ffffffff fffffffd",
                     busy, v_HI, v_LO);
        end
        step();
    endtask

    task automatic test_div_edge();
        for (int i = 0; i <= DL; i++) begin
            drive((i == 0) ? 4'd3 : 4'd0, 32'h8000_0000, 32'hFFFF_FFFF,
                  1'b0, 1'b0);
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_chk++;
        if ({v_HI, v_LO} !== {32'h0, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL div_ovf got=%h %h exp=00000000 80000000",
                     v_HI, v_LO);
        end
        for (int i = 0; i <= DL; i++) begin
            drive((i == 0) ? 4'd4 : 4'd0, 32'd7, 32'd0, 1'b0, 1'b0);
            n_chk++;
            if (busy !== (i != 0)) begin
                n_fail++;
                $display("FAIL divz_busy i=%0d got=%b exp=%b",
                         i, busy, i != 0);
            end
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_chk++;
        if ({busy, v_HI, v_LO} !== {1'b0, 32'h0, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL divz_keep got=%b %h %h exp=0 00000000 80000000",
                     busy, v_HI, v_LO);
        end
        step();
    endtask

    task automatic test_mtx();
        drive(4'd5, 32'h1234_5678, 32'd0, 1'b1, 1'b0);
        n_chk++;
        if ({start, busy, stall_MD} !== 3'b000) begin
            n_fail++;
            $display("FAIL mthi_stall got=%b exp=000",
                     {start, busy, stall_MD});
        end
        step();
        drive(4'd7, 32'd0, 32'd0, 1'b1, 1'b0);
        n_chk++;
        if ({v_MD_E, stall_MD} !== {32'h1234_5678, 1'b0}) begin
            n_fail++;
            $display("FAIL mfhi_read got=%h %b exp=12345678 0",
                     v_MD_E, stall_MD);
        end
        step();
        drive(4'd6, 32'hCAFE_BABE, 32'd0, 1'b1, 1'b0);
        step();
        drive(4'd8, 32'd0, 32'd0, 1'b1, 1'b0);
        n_chk++;
        if ({v_MD_E, stall_MD, busy} !== {32'hCAFE_BABE, 2'b00}) begin
            n_fail++;
            $display("FAIL mflo_read got=%h %b%b exp=cafebabe 00",
                     v_MD_E, stall_MD, busy);
        end
        step();
    endtask

    task automatic test_stall_ignore();
        for (int i = 0; i <= ML; i++) begin
            if (i == 0)
                drive(4'd1, 32'd7, 32'd6, 1'b1, 1'b0);
            else
                drive((i == 2) ? 4'd1 : 4'd0, 32'd3, 32'd3, 1'b1, 1'b0);
            n_chk++;
            if (stall_MD !== 1'b1 || start !== (i == 0)) begin
                n_fail++;
                $display("FAIL stall_hold i=%0d got=%b%b exp=1%b",
                         i, stall_MD, start, i == 0);
            end
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        n_chk++;
        if ({stall_MD, busy, v_HI, v_LO} !== {2'b00, 32'd0, 32'd42}) begin
            n_fail++;
            $display("FAIL stall_release got=%b%b %h %h exp=00 0 2a",
                     stall_MD, busy, v_HI, v_LO);
        end
        step();
    endtask

    task automatic test_reset_abort();
        drive(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        step();
        for (int i = 1; i < 4; i++) begin
            drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < DL + 2; i++) begin
            drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
            n_chk++;
            if ({busy, v_HI, v_LO} !== 65'd0) begin
                n_fail++;
                $display("FAIL reset_abort i=%0d got=%b %h %h exp=0",
                         i, busy, v_HI, v_LO);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= ML + DL + 1; i++) begin
            if (i == 0)
                drive(4'd2, 32'hDEAD_BEEF, 32'h10, 1'b1, 1'b0);
            else if (i == ML + 1)
                drive(4'd4, 32'd1000, 32'd33, 1'b1, 1'b0);
            else
                drive(4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b i=%0d got=%h exp=%h",
                         i, obs, exp_vec());
            end
            if (i == ML + 1) begin
                n_chk++;
                if ({start, busy, v_LO} !== {2'b10, 32'hDEAD_BEEF << 4}) begin
                    n_fail++;
                    $display("FAIL b2b_accept got=%b%b %h exp=10 %h",
                             start, busy, v_LO, 32'hDEAD_BEEF << 4);
                end
            end
            step();
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_chk++;
        if ({v_HI, v_LO} !== {32'd10, 32'd30}) begin
            n_fail++;
            $display("FAIL b2b_divu got=%h %h exp=0000000a 0000001e",
                     v_HI, v_LO);
        end
        step();
    endtask

    task automatic test_random();
        logic [31:0] sp [4];
        logic [3:0]  op;
        logic [31:0] a, b;
        sp = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};
        for (int i = 0; i < 600; i++) begin
            op = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(0, 8));
            a  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)]
                                             : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)]
                                             : $urandom;
            drive(op, a, b, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 80) == 0);
            n_chk++;
            if (obs !== exp_vec()) begin
                n_fail++;
                $display("FAIL random i=%0d op=%0d got=%h exp=%h",
                         i, op, obs, exp_vec());
            end
            step();
        end
    endtask

    initial begin
        drive(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        test_reset();
        test_mult();
        test_multu_div();
        test_div_edge();
        test_mtx();
        test_stall_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
